// File: rtl/alu_result_display.sv
// Holds the last ALU result/op code and scans them onto a 3-digit multiplexed
// common-anode seven-segment display (ones, tens, op), all outputs registered.
module alu_result_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int HEX_MODE    = 0,
   parameter int LZB         = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] result,
   input  logic [2:0] operation,
   output logic       ack,
   output logic [2:0] an,
   output logic [6:0] seg
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      DIG_ONES = 2'd0,
      DIG_TENS = 2'd1,
      DIG_OP   = 2'd2
   } dig_e;

   logic [CW-1:0] cnt_q, cnt_d;
   dig_e          scan_idx_q, scan_idx_d;
   logic [3:0]    held_res_q, held_res_d;
   logic [2:0]    held_op_q, held_op_d;
   logic          ack_q, ack_d;
   logic [2:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic [3:0]    ones_val;
   logic [3:0]    tens_val;
   logic          tens_blank;

   // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         scan_idx_q <= DIG_ONES;
         held_res_q <= '0;
         held_op_q  <= '0;
         ack_q      <= 1'b0;
         an_q       <= 3'b111;
         seg_q      <= SEG_BLANK;
      end else begin
         cnt_q      <= cnt_d;
         scan_idx_q <= scan_idx_d;
         held_res_q <= held_res_d;
         held_op_q  <= held_op_d;
         ack_q      <= ack_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   // Scan counter and digit selector; idx only moves on a counter wrap.
   always_comb begin
      cnt_d      = cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         case (scan_idx_q)
            DIG_ONES: scan_idx_d = DIG_TENS;
            DIG_TENS: scan_idx_d = DIG_OP;
            default:  scan_idx_d = DIG_ONES;
         endcase
      end
   end

   always_comb begin
      held_res_d = held_res_q;
      held_op_d  = held_op_q;
      ack_d      = load;
      if (load) begin
         held_res_d = result;
         held_op_d  = operation;
      end
   end

   // Decode from next-state values so a capture or digit change shows on the
   // same edge that commits it.
   always_comb begin
      ones_val   = held_res_d;
      tens_val   = 4'd0;
      tens_blank = 1'b1;
      if (HEX_MODE == 0) begin
         if (held_res_d >= 4'd10) begin
            ones_val = held_res_d - 4'd10;
            tens_val = 4'd1;
         end
         tens_blank = (LZB != 0) && (held_res_d < 4'd10);
      end
   end

   always_comb begin
      an_d  = 3'b111;
      seg_d = SEG_BLANK;
      case (scan_idx_d)
         DIG_ONES: begin
            an_d  = 3'b110;
            seg_d = glyph(ones_val);
         end
         DIG_TENS: begin
            an_d  = 3'b101;
            seg_d = tens_blank ? SEG_BLANK : glyph(tens_val);
         end
         DIG_OP: begin
            an_d  = 3'b011;
            seg_d = glyph({1'b0, held_op_d});
         end
         default: begin
            an_d  = 3'b111;
            seg_d = SEG_BLANK;
         end
      endcase
   end

   assign ack = ack_q;
   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Bench for alu_result_display: three instances (decimal/LZB, decimal/no-LZB,
// hex) share stimulus; a cycle model feeds a scoreboard, plus table checks.
module tb_alu_result_display;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [3:0] result;
   logic [2:0] operation;

   logic       ack_a, ack_b, ack_c;
   logic [2:0] an_a, an_b, an_c;
   logic [6:0] seg_a, seg_b, seg_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_result_display #(.REFRESH_DIV(RD), .HEX_MODE(0), .LZB(1)) u_dec (
      .clk(clk), .rst_n(rst_n), .load(load), .result(result), .operation(operation),
      .ack(ack_a), .an(an_a), .seg(seg_a));
   alu_result_display #(.REFRESH_DIV(RD), .HEX_MODE(0), .LZB(0)) u_nolzb (
      .clk(clk), .rst_n(rst_n), .load(load), .result(result), .operation(operation),
      .ack(ack_b), .an(an_b), .seg(seg_b));
   alu_result_display #(.REFRESH_DIV(RD), .HEX_MODE(1), .LZB(1)) u_hex (
      .clk(clk), .rst_n(rst_n), .load(load), .result(result), .operation(operation),
      .ack(ack_c), .an(an_c), .seg(seg_c));

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [6:0] lut [16];
   initial begin
      lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   end

   function automatic logic [6:0] model_seg(input int idx, input int res, input int op,
                                            input bit hex, input bit lzb);
      if (idx == 0) return hex ? lut[res] : lut[res % 10];
      if (idx == 1) begin
         if (hex || (lzb && res < 10)) return 7'h7F;
         return lut[res / 10];
      end
      return lut[op];
   endfunction

   typedef struct {
      logic       ack;
      logic [2:0] an;
      logic [6:0] seg_a, seg_b, seg_c;
   } exp_t;

   exp_t sb [$];
   int   m_cnt, m_idx, m_res, m_op;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0; m_idx <= 0; m_res <= 0; m_op <= 0;
         sb.delete();
      end else begin : step
         int   nc, ni, nr, no;
         exp_t e;
         nc = m_cnt + 1; ni = m_idx;
         if (m_cnt == RD - 1) begin nc = 0; ni = (m_idx + 1) % 3; end
         nr = load ? int'(result) : m_res;
         no = load ? int'(operation) : m_op;
         e.ack   = load;
         e.an    = (ni == 0) ? 3'b110 : (ni == 1) ? 3'b101 : 3'b011;
         e.seg_a = model_seg(ni, nr, no, 1'b0, 1'b1);
         e.seg_b = model_seg(ni, nr, no, 1'b0, 1'b0);
         e.seg_c = model_seg(ni, nr, no, 1'b1, 1'b1);
         sb.push_back(e);
         m_cnt <= nc; m_idx <= ni; m_res <= nr; m_op <= no;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_an", {an_a, an_b, an_c}, 9'h1FF);
         chk("rst_seg_a", seg_a, 7'h7F);
         chk("rst_seg_c", seg_c, 7'h7F);
         chk("rst_ack", {ack_a, ack_b, ack_c}, 0);
      end else if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin : cmp
         exp_t e;
         e = sb.pop_front();
         chk("sb_ack", {ack_a, ack_b, ack_c}, {3{e.ack}});
         chk("sb_an_a", an_a, e.an);
         chk("sb_an_b", an_b, e.an);
         chk("sb_an_c", an_c, e.an);
         chk("sb_seg_dec", seg_a, e.seg_a);
         chk("sb_seg_nolzb", seg_b, e.seg_b);
         chk("sb_seg_hex", seg_c, e.seg_c);
      end
   end

   // ---------------- table-driven vectors ----------------
   typedef struct {
      logic [3:0] res;
      logic [2:0] op;
      logic [6:0] ones, tens, opseg, tens_nolzb, ones_hex;
   } vec_t;

   vec_t vecs [7];

   task automatic do_load(input logic [3:0] r, input logic [2:0] o);
      @(negedge clk); #1;
      load = 1'b1; result = r; operation = o;
      @(negedge clk);
      chk("ack_hi", ack_a, 1);
      #1 load = 1'b0;
      @(negedge clk);
      chk("ack_lo", ack_a, 0);
   endtask

   initial begin
      vecs[0] = '{4'd5,  3'd0, 7'h12, 7'h7F, 7'h40, 7'h40, 7'h12};
      vecs[1] = '{4'd13, 3'd3, 7'h30, 7'h79, 7'h30, 7'h79, 7'h21};
      vecs[2] = '{4'd4,  3'd5, 7'h19, 7'h7F, 7'h12, 7'h40, 7'h19};
      vecs[3] = '{4'd11, 3'd6, 7'h79, 7'h79, 7'h02, 7'h79, 7'h03};
      vecs[4] = '{4'd15, 3'd7, 7'h12, 7'h79, 7'h78, 7'h79, 7'h0E};
      vecs[5] = '{4'd0,  3'd1, 7'h40, 7'h7F, 7'h79, 7'h40, 7'h40};
      vecs[6] = '{4'd10, 3'd2, 7'h40, 7'h79, 7'h24, 7'h79, 7'h08};

      rst_n = 1'b0; load = 1'b0; result = '0; operation = '0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("first_an", an_a, 3'b110);
      chk("first_seg", seg_a, 7'h40);
      repeat (12) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         do_load(vecs[v].res, vecs[v].op);
         for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            case (an_a)
               3'b110: begin
                  chk("tbl_ones", seg_a, vecs[v].ones);
                  chk("tbl_ones_hex", seg_c, vecs[v].ones_hex);
               end
               3'b101: begin
                  chk("tbl_tens", seg_a, vecs[v].tens);
                  chk("tbl_tens_nolzb", seg_b, vecs[v].tens_nolzb);
                  chk("tbl_tens_hex", seg_c, 7'h7F);
               end
               default: chk("tbl_op", seg_a, vecs[v].opseg);
            endcase
         end
      end

      // Load on the edge where the scan moves ones->tens.
      begin : wrap_load
         bit hit = 0;
         for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (m_cnt == RD - 1 && m_idx == 0) hit = 1;
         end
         chk("wrap_found", hit, 1);
         #1 load = 1'b1; result = 4'd12; operation = 3'd4;
         @(negedge clk);
         chk("wrap_an", an_a, 3'b101);
         chk("wrap_seg", seg_a, 7'h79);
         #1 load = 1'b0;
      end

      // Async reset mid-slot with a load pending: clears without a clock.
      @(negedge clk); #1;
      load = 1'b1; result = 4'd9; operation = 3'd5;
      rst_n = 1'b0;
      #1;
      chk("async_an", {an_a, an_b, an_c}, 9'h1FF);
      chk("async_seg", seg_a, 7'h7F);
      chk("async_ack", ack_a, 0);
      repeat (2) @(negedge clk);
      #1 load = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_seg", seg_a, 7'h40);

      // Back-to-back op sweep.
      @(negedge clk); #1 load = 1'b1;
      for (int o = 0; o < 8; o++) begin
         operation = 3'(o); result = 4'(o + 6);
         @(negedge clk);
         chk("sweep_ack", ack_a, 1);
         #1;
      end
      load = 1'b0;
      begin : op_slot
         bit seen = 0;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (an_a == 3'b011) begin
               seen = 1;
               chk("sweep_op_last", seg_a, 7'h78);
            end
         end
         chk("sweep_op_seen", seen, 1);
      end
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
